spi_frame_master: RTL

//  Parametrised synchronous SPI master; successor to the fixed 8-bit, 2-byte bench master.
//  - Generates sclk, ss and mosi from the system clock.
//  - Shifts a frame of WORDS words of WORD_W bits each, MSB first.
//  - Captures miso into a parallel frame.
//  - Drives the motor-controller SPI slave: register writes, reads, frame-gap pacing.

---
 rtl/spi_pkg.sv | 39 +++
 rtl/spi_clkdiv.sv | 47 ++++
 rtl/spi_frame_master.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Purpose  : Shared state encoding, default timing and width helper for the
//            SPI frame master.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_GAP   = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        LEAD_S  = ST_LEAD,
        SHIFT   = ST_SHIFT,
        GAP_S   = ST_GAP,
        TRAIL_S = ST_TRAIL,
        DONE_S  = ST_DONE
    } state_t;

    localparam int DEF_WORD_W = 8;
    localparam int DEF_WORDS  = 2;
    localparam int DEF_HALF   = 16;
    localparam int DEF_LEAD   = 5;
    localparam int DEF_GAP    = 5;
    localparam int DEF_TRAIL  = 5;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkdiv.sv
`default_nettype none
// ============================================================================
// Module   : spi_clkdiv
// Purpose  : Half-period counter; strobes at the end of the low half (rise)
//            and the end of the high half (fall). Cleared while disabled.
// Revision : 1.0 - initial release
// ============================================================================
module spi_clkdiv
    import spi_pkg::*;
#(
    parameter int HALF = DEF_HALF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_rise,
    output logic o_fall
);

    localparam int              CW     = clog2_min1(HALF);
    localparam logic [CW-1:0]   c_last = CW'(HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_end;

    assign w_end  = i_en && (r_cnt == c_last);
    assign o_rise = w_end && !r_phase;
    assign o_fall = w_end &&  r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_end) begin
            r_cnt   <= '0;
            r_phase <= !r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_master
// Purpose  : Parametrised SPI master shifting WORDS x WORD_W bit frames, MSB
//            first. Optional abort input when SPI_ABORT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int WORDS  = DEF_WORDS,
    parameter int HALF   = DEF_HALF,
    parameter int LEAD   = DEF_LEAD,
    parameter int GAP    = DEF_GAP,
    parameter int TRAIL  = DEF_TRAIL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [WORD_W*WORDS-1:0] tx_frame,
`ifdef SPI_ABORT_EN
    input  logic                    abort,
`endif
    input  logic                    miso,
    output logic [WORD_W*WORDS-1:0] rx_frame,
    output logic                    busy,
    output logic                    done,
    output logic                    sclk,
    output logic                    ss,
    output logic                    mosi
);

    localparam int FW   = WORD_W * WORDS;
    localparam int BW   = clog2_min1(WORD_W + 1);
    localparam int WW   = clog2_min1(WORDS + 1);
    localparam int TMAX = (LEAD > GAP) ? ((LEAD > TRAIL) ? LEAD : TRAIL)
                                       : ((GAP > TRAIL) ? GAP : TRAIL);
    localparam int TW   = clog2_min1(TMAX + 1);

    localparam logic [BW-1:0] c_bit_last   = BW'(WORD_W - 1);
    localparam logic [WW-1:0] c_word_last  = WW'(WORDS - 1);
    localparam logic [TW-1:0] c_lead_last  = TW'(LEAD - 1);
    localparam logic [TW-1:0] c_gap_last   = TW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [TW-1:0] c_trail_last = TW'(TRAIL - 1);

    state_t        r_state;
    logic [FW-1:0] r_tx;
    logic [FW-1:0] r_rx;
    logic [BW-1:0] r_bit;
    logic [WW-1:0] r_word;
    logic [TW-1:0] r_tcnt;
    logic          w_rise;
    logic          w_fall;
    logic          w_abort;
    logic          w_div_en;

`ifdef SPI_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_div_en = (r_state == SHIFT);

    spi_clkdiv #(
        .HALF   (HALF)
    ) u_clkdiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_div_en),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_tx     <= '0;
            r_rx     <= '0;
            r_bit    <= '0;
            r_word   <= '0;
            r_tcnt   <= '0;
            rx_frame <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sclk     <= 1'b1;
            ss       <= 1'b0;
            mosi     <= 1'b0;
        end else if (w_abort && busy) begin
            r_state <= IDLE;
            r_bit   <= '0;
            r_word  <= '0;
            r_tcnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b1;
            ss      <= 1'b0;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !busy) begin
                        r_tx    <= tx_frame;
                        r_tcnt  <= '0;
                        r_state <= LEAD_S;
                        ss      <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                LEAD_S: begin
                    if (r_tcnt == c_lead_last) begin
                        r_tcnt  <= '0;
                        r_state <= SHIFT;
                        sclk    <= 1'b0;
                        mosi    <= r_tx[FW-1];
                        r_tx    <= r_tx << 1;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_rise) begin
                        sclk <= 1'b1;
                        r_rx <= (r_rx << 1) | FW'(miso);
                    end else if (w_fall) begin
                        if (r_bit != c_bit_last) begin
                            r_bit <= r_bit + 1'b1;
                            sclk  <= 1'b0;
                            mosi  <= r_tx[FW-1];
                            r_tx  <= r_tx << 1;
                        end else begin
                            r_bit <= '0;
                            if (r_word == c_word_last) begin
                                r_word  <= '0;
                                r_state <= TRAIL_S;
                            end else begin
                                r_word <= r_word + 1'b1;
                                // Without a gap the next word's first fall lands on this edge.
                                if (GAP == 0) begin
                                    sclk <= 1'b0;
                                    mosi <= r_tx[FW-1];
                                    r_tx <= r_tx << 1;
                                end else begin
                                    r_state <= GAP_S;
                                end
                            end
                        end
                    end
                end
                GAP_S: begin
                    if (r_tcnt == c_gap_last) begin
                        r_tcnt  <= '0;
                        r_state <= SHIFT;
                        sclk    <= 1'b0;
                        mosi    <= r_tx[FW-1];
                        r_tx    <= r_tx << 1;
                    end else begin
                        r_tcnt  <= r_tcnt + 1'b1;
                    end
                end
                TRAIL_S: begin
                    if (r_tcnt == c_trail_last) begin
                        r_tcnt   <= '0;
                        r_state  <= DONE_S;
                        ss       <= 1'b0;
                        mosi     <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rx_frame <= r_rx;
                    end else begin
                        r_tcnt   <= r_tcnt + 1'b1;
                    end
                end
                DONE_S: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
